reel_spinner: RTL and testbench
===============================

Name: reel_spinner

Overview:
- Upstream stage of the slot-machine scoring block: generates the four reel digits and the score-request strobe it consumes.
- On a spin request, all four reels cycle through digits 0-9 from pseudo-random start positions, then stop one at a time, left to right.
- Presents each digit as an active-low 7-segment pattern on num1..num4.
- Holds to_score high while the final result is displayed.
- Refuses to start a spin while the player is broke.

Parameters:
- TICK_DIV, 1000000: clock cycles per reel step tick; must be >= 1.
- MIN_SPIN, 100: ticks all reels run before reel 1 may begin stopping.
- STOP_GAP, 30: base ticks per stop phase; the actual phase length is STOP_GAP + LFSR[3:0].

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- spin_btn  in  1  spin request; a debounced, synchronous level. Only the rising edge acts.
- is_broke  in  1  player cannot afford a spin; blocks spin start.
- num1  out  7  reel 1 digit, active-low 7-segment pattern {g..a}.
- num2  out  7  reel 2 digit, same encoding.
- num3  out  7  reel 3 digit, same encoding.
- num4  out  7  reel 4 digit, same encoding.
- to_score  out  1  result valid; high in RESULT only.
- spinning  out  1  high in SPIN and STOP1..STOP4.

Behaviour:
- Digit encoding, index 0-9:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Outputs are registered decodes of 4-bit reel indices. No other pattern may ever appear.
- Tick generation:
  - A free counter runs 0..TICK_DIV-1 in every state.
  - tick is a one-cycle strobe when the counter equals TICK_DIV-1.
  - The counter clears on reset only.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every clock; seeded 16'hACE1 on reset.
  - Never reaches zero.
- Rising edge detect: a spin_btn delay register, cleared on reset. A held button never retriggers.
- Reset:
  - State IDLE; all reel indices 0, so num1..num4 = 1000000.
  - to_score = 0, spinning = 0, stop counter = 0.
  - Reset mid-spin aborts immediately with the same values on the next cycle.
- FSM:
  - IDLE: on a spin_btn rising edge with is_broke = 0, go to SPIN.
    - At that edge, load reel k index = LFSR nibble k mod 10 (values 10-15 subtract 10).
    - Load stop counter = MIN_SPIN.
  - RESULT: a spin_btn rising edge with is_broke = 0 behaves exactly as in IDLE. With is_broke = 1, stay in RESULT.
  - SPIN:
    - Every reel not yet stopped advances +1 per tick, wrapping 9 to 0.
    - Stop counter decrements per tick.
    - On the tick where the counter is 0: go to STOP1 and load counter = STOP_GAP + LFSR[3:0].
  - STOPk (k = 1..4):
    - Reels k..4 advance per tick; reels < k are frozen.
    - On the tick where the counter is 0, reel k freezes and does not advance on that tick.
    - k < 4: go to STOP(k+1) and reload the counter as above.
    - k = 4: go to RESULT.
- Outputs by state:
  - to_score = 1 exactly in RESULT, starting the first cycle after entry. It falls in the cycle after the accepting spin edge.
  - spinning = 1 in SPIN and STOP1..4.
- Ignored inputs:
  - spin_btn edges while spinning are ignored.
  - is_broke is sampled only when starting a spin.
- Spin duration per spin: at most (MIN_SPIN+1) + 4*(STOP_GAP+16) ticks.
- Simultaneous rst and spin_btn edge: reset wins.

Test Plan:
All scenarios use TICK_DIV = 1, MIN_SPIN = 4, STOP_GAP = 2.
- Reset: rst held 2 cycles, then released -> num1..num4 = 7'b1000000, to_score = 0, spinning = 0 for 20 cycles with no input.
- Broke lockout: is_broke = 1, spin_btn pulsed high 3 cycles -> spinning stays 0 and digits stay 1000000 for 200 cycles. Same with is_broke = 1 while in RESULT -> to_score stays 1.
- Full spin: spin_btn rising edge with is_broke = 0 ->
  - spinning = 1 on the next cycle.
  - Reels stop in order 1,2,3,4 within 5+4*18 = 77 cycles.
  - Then spinning = 0 and to_score = 1, held for 100 cycles.
  - Every output is one of the 10 legal patterns throughout.
- Wrap and freeze: during SPIN, capture a reel at 0010000 (9) -> next tick shows 1000000 (0). After reel 1 freezes, num1 is constant while num4 still changes each tick.
- Respin and hold: spin_btn held high across the end of a spin -> no retrigger. Release, then press -> to_score drops the cycle after the edge and stays 0 until the new RESULT.
- Mid-spin reset: rst asserted during STOP2 -> next cycle all digits 1000000, to_score = 0, spinning = 0. A new spin then completes normally.

Source files
------------

// File: rtl/reel_spinner.sv
// Four-reel digit generator for the slot-machine scorer.
// Reels start from LFSR-derived digits, spin, then stop left to right; the result is flagged on to_score.
module reel_spinner #(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned MIN_SPIN = 100,
    parameter int unsigned STOP_GAP = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin_btn,
    input  logic       is_broke,
    output logic [6:0] num1,
    output logic [6:0] num2,
    output logic [6:0] num3,
    output logic [6:0] num4,
    output logic       to_score,
    output logic       spinning
);

    localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_MAX = (MIN_SPIN > STOP_GAP + 15) ? MIN_SPIN : STOP_GAP + 15;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_STOP1,
        S_STOP2,
        S_STOP3,
        S_STOP4,
        S_RESULT
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick_c;
    logic [15:0]   lfsr;
    logic          btn_q;
    logic [CW-1:0] stop_cnt;
    logic [3:0]    reel     [4];
    logic [3:0]    reel_nxt [4];
    logic [3:0]    adv_c;
    logic          rise_c;
    logic          start_c;
    logic          cnt_zero_c;
    logic          stopping_c;
    logic [1:0]    stop_idx_c;
    logic [CW-1:0] reload_c;

    function automatic logic [3:0] mod10(input logic [3:0] n);
        return (n >= 4'd10) ? n - 4'd10 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1000000;
        endcase
    endfunction

    // Free-running reel step tick
    assign tick_c = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= 16'hACE1;
            btn_q <= 1'b0;
        end else begin
            lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            btn_q <= spin_btn;
        end
    end

    assign rise_c     = spin_btn & ~btn_q;
    assign start_c    = rise_c & ~is_broke & ((state == S_IDLE) | (state == S_RESULT));
    assign cnt_zero_c = (stop_cnt == '0);
    assign reload_c   = CW'(STOP_GAP) + CW'(lfsr[3:0]);

    always_comb begin
        stopping_c = 1'b0;
        stop_idx_c = 2'd0;
        case (state)
            S_STOP1: begin stopping_c = 1'b1; stop_idx_c = 2'd0; end
            S_STOP2: begin stopping_c = 1'b1; stop_idx_c = 2'd1; end
            S_STOP3: begin stopping_c = 1'b1; stop_idx_c = 2'd2; end
            S_STOP4: begin stopping_c = 1'b1; stop_idx_c = 2'd3; end
            default: ;
        endcase
    end

    // A reel advances on a tick unless it sits left of the stopping reel or is freezing now
    always_comb begin
        adv_c = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            reel_nxt[k] = reel[k];
            adv_c[k] = tick_c & ((state == S_SPIN) |
                       (stopping_c & ((2'(k) > stop_idx_c) | ((2'(k) == stop_idx_c) & ~cnt_zero_c))));
            if (start_c) begin
                reel_nxt[k] = mod10(lfsr[4*k +: 4]);
            end else if (adv_c[k]) begin
                reel_nxt[k] = (reel[k] == 4'd9) ? 4'd0 : reel[k] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            stop_cnt <= '0;
            to_score <= 1'b0;
            spinning <= 1'b0;
            num1     <= 7'b1000000;
            num2     <= 7'b1000000;
            num3     <= 7'b1000000;
            num4     <= 7'b1000000;
            for (int k = 0; k < 4; k++) begin
                reel[k] <= 4'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                reel[k] <= reel_nxt[k];
            end
            num1 <= seg7(reel_nxt[0]);
            num2 <= seg7(reel_nxt[1]);
            num3 <= seg7(reel_nxt[2]);
            num4 <= seg7(reel_nxt[3]);
            case (state)
                S_IDLE, S_RESULT: begin
                    if (start_c) begin
                        state    <= S_SPIN;
                        stop_cnt <= CW'(MIN_SPIN);
                        to_score <= 1'b0;
                        spinning <= 1'b1;
                    end
                end
                S_SPIN, S_STOP1, S_STOP2, S_STOP3: begin
                    if (tick_c) begin
                        if (cnt_zero_c) begin
                            stop_cnt <= reload_c;
                            case (state)
                                S_SPIN:  state <= S_STOP1;
                                S_STOP1: state <= S_STOP2;
                                S_STOP2: state <= S_STOP3;
                                default: state <= S_STOP4;
                            endcase
                        end else begin
                            stop_cnt <= stop_cnt - CW'(1);
                        end
                    end
                end
                S_STOP4: begin
                    if (tick_c) begin
                        if (cnt_zero_c) begin
                            state    <= S_RESULT;
                            to_score <= 1'b1;
                            spinning <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    to_score <= 1'b0;
                    spinning <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reel_spinner.sv
// Directed bench for reel_spinner with a cycle-level reference model of the reel game.
module tb_reel_spinner;

    localparam int unsigned TICK_DIV = 1;
    localparam int unsigned MIN_SPIN = 4;
    localparam int unsigned STOP_GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spin_btn = 1'b0;
    logic       is_broke = 1'b0;
    logic [6:0] num1, num2, num3, num4;
    logic       to_score, spinning;

    int tests = 0;
    int fails = 0;
    int wraps = 0;

    always #5 clk = ~clk;

    reel_spinner #(.TICK_DIV(TICK_DIV), .MIN_SPIN(MIN_SPIN), .STOP_GAP(STOP_GAP)) dut (
        .clk(clk), .rst(rst), .spin_btn(spin_btn), .is_broke(is_broke),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .to_score(to_score), .spinning(spinning)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (p === seg(d)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] digit(input int k);
        case (k)
            0: return num1;
            1: return num2;
            2: return num3;
            default: return num4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 spin, 2..5 stopping reel 1..4, 6 result
    int          m_phase, m_cnt, m_tcnt;
    int          m_reel [4];
    logic [15:0] m_lfsr;
    bit          m_prev, m_rise, m_tk;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_tcnt = 0; m_prev = 1'b0; m_lfsr = 16'hACE1;
            for (int k = 0; k < 4; k++) m_reel[k] = 0;
            m_valid = 1'b1;
        end else begin
            m_tk   = (m_tcnt == int'(TICK_DIV) - 1);
            m_tcnt = m_tk ? 0 : m_tcnt + 1;
            m_rise = spin_btn && !m_prev;
            if ((m_phase == 0 || m_phase == 6) && m_rise && !is_broke) begin
                for (int k = 0; k < 4; k++) m_reel[k] = int'((m_lfsr >> (4 * k)) & 16'hF) % 10;
                m_cnt   = int'(MIN_SPIN);
                m_phase = 1;
            end else if (m_phase >= 1 && m_phase <= 5 && m_tk) begin
                for (int k = 0; k < 4; k++)
                    if (m_phase == 1 || k > m_phase - 2 || (k == m_phase - 2 && m_cnt != 0))
                        m_reel[k] = (m_reel[k] + 1) % 10;
                if (m_cnt == 0) begin
                    m_phase++;
                    m_cnt = int'(STOP_GAP) + int'(m_lfsr[3:0]);
                end else begin
                    m_cnt--;
                end
            end
            m_prev = spin_btn;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_outputs",
                32'({num1, num2, num3, num4, to_score, spinning}),
                32'({seg(m_reel[0]), seg(m_reel[1]), seg(m_reel[2]), seg(m_reel[3]),
                     m_phase == 6, m_phase >= 1 && m_phase <= 5}));
            chk("legal_patterns", 32'(legal(num1) && legal(num2) && legal(num3) && legal(num4)), 32'd1);
        end
    end

    // Press, then follow one spin to its end, checking freeze order, wrap and timing
    task automatic run_spin(input bit hold);
        logic [6:0] prv [4];
        logic [6:0] cur;
        int         fat [4];
        bit         frz [4];
        int         cyc;
        @(negedge clk);
        spin_btn = 1'b1;
        @(negedge clk);
        chk("spin_start", 32'({spinning, to_score}), 32'b10);
        for (int k = 0; k < 4; k++) begin prv[k] = digit(k); fat[k] = 0; frz[k] = 1'b0; end
        cyc = 0;
        while (spinning === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!hold && cyc == 1) spin_btn = 1'b0;
            if (spinning) begin
                chk("score_low_while_spinning", 32'(to_score), 32'd0);
                chk("num4_moving", 32'(digit(3) != prv[3]), 32'd1);
                if (prv[3] == seg(9)) begin
                    chk("wrap_9_to_0", 32'(digit(3)), 32'(seg(0)));
                    wraps++;
                end
            end
            for (int k = 0; k < 4; k++) begin
                cur = digit(k);
                if (frz[k]) chk("frozen_reel_stable", 32'(cur), 32'(prv[k]));
                else if (cur == prv[k]) begin frz[k] = 1'b1; fat[k] = cyc; end
                prv[k] = cur;
            end
        end
        chk("spin_ended", 32'({spinning, to_score}), 32'b01);
        chk("spin_len_le_77", 32'(cyc <= 77), 32'd1);
        chk("stop_order", 32'(fat[0] > 0 && fat[0] < fat[1] && fat[1] < fat[2] && fat[2] < fat[3]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        logic [27:0] final_digits;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_digits", 32'({num1, num2, num3, num4}), 32'({4{7'b1000000}}));
            chk("reset_flags", 32'({to_score, spinning}), 32'b00);
        end

        is_broke = 1'b1;
        spin_btn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 2) spin_btn = 1'b0;
            chk("broke_idle_digits", 32'({num1, num2, num3, num4, spinning}), 32'({{4{7'b1000000}}, 1'b0}));
        end
        is_broke = 1'b0;

        run_spin(1'b0);
        final_digits = {num1, num2, num3, num4};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("result_hold", 32'({to_score, spinning, num1, num2, num3, num4}), 32'({2'b10, final_digits}));
        end

        is_broke = 1'b1;
        spin_btn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 2) spin_btn = 1'b0;
            chk("broke_result_hold", 32'({to_score, spinning}), 32'b10);
        end
        is_broke = 1'b0;

        run_spin(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("held_no_retrigger", 32'({to_score, spinning}), 32'b10);
        end
        spin_btn = 1'b0;
        repeat (2) @(negedge clk);
        run_spin(1'b0);

        @(negedge clk);
        spin_btn = 1'b1;
        @(negedge clk);
        spin_btn = 1'b0;
        w = 0;
        while (m_phase != 3 && w < 100) begin @(negedge clk); w++; end
        chk("reached_stop2", 32'(m_phase), 32'd3);
        chk("stop2_spinning", 32'(spinning), 32'd1);
        rst = 1'b1;
        spin_btn = 1'b1;
        @(negedge clk);
        chk("midspin_reset", 32'({num1, num2, num3, num4, to_score, spinning}),
            32'({{4{7'b1000000}}, 2'b00}));
        rst = 1'b0;
        @(negedge clk);
        // Start right after reset uses seed 16'hACE1: nibbles 1,E,C,A -> digits 1,4,2,0
        chk("seed_start_digits", 32'({num1, num2, num3, num4}),
            32'({7'b1111001, 7'b0011001, 7'b0100100, 7'b1000000}));
        chk("seed_start_flags", 32'({to_score, spinning}), 32'b01);
        spin_btn = 1'b0;
        w = 0;
        while (spinning === 1'b1 && w < 100) begin @(negedge clk); w++; end
        chk("seed_spin_done", 32'({to_score, spinning}), 32'b10);
        // Reel 1: start 1, 5 spin ticks, STOP1 gap 2+7 -> 9 more advances -> digit 5
        chk("seed_reel1_final", 32'(num1), 32'(7'b0010010));
        repeat (2) @(negedge clk);
        run_spin(1'b0);

        chk("wraps_observed", 32'(wraps > 0), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
